// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: two request/response channel pairs.
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both high; the source holds valid and payload
// stable until that edge, and may drop valid earlier, in which case nothing
// is transferred.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_op1;
    logic [DATA_W-1:0] req0_op2;
    logic [OP_W-1:0]   req0_aluop;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_result;
    logic              rsp0_zero;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_op1;
    logic [DATA_W-1:0] req1_op2;
    logic [OP_W-1:0]   req1_aluop;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_result;
    logic              rsp1_zero;
    logic              rsp1_err;

    // Requester side (the two clients).
    modport master (
        output req0_valid, req0_op1, req0_op2, req0_aluop, rsp0_ready,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        output req1_valid, req1_op1, req1_op2, req1_aluop, rsp1_ready,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_aluop, rsp0_ready,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        input  req1_valid, req1_op1, req1_op2, req1_aluop, rsp1_ready,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle with the ALU driven from latched
// operands, then RESP holds the captured result until the owner accepts it.
// Opcodes the ALU does not implement come back with err set and zero data.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              legal_q, legal_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [OP_W-1:0]   aluop_q, aluop_d;

    logic grant0;
    logic grant1;
    logic rsp_hs;

    // Opcodes the attached ALU actually implements.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_W'(0), OP_W'(1), OP_W'(2), OP_W'(6), OP_W'(7),
            OP_W'(8), OP_W'(9), OP_W'(10), OP_W'(13): ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        rsp_hs = (state_q == RESP) & (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
    end

    assign bus.req0_ready  = (state_q == IDLE) & grant0;
    assign bus.req1_ready  = (state_q == IDLE) & grant1;
    assign bus.rsp0_valid  = (state_q == RESP) & ~owner_q;
    assign bus.rsp1_valid  = (state_q == RESP) & owner_q;
    assign bus.rsp0_result = result_q;
    assign bus.rsp1_result = result_q;
    assign bus.rsp0_zero   = zero_q;
    assign bus.rsp1_zero   = zero_q;
    assign bus.rsp0_err    = err_q;
    assign bus.rsp1_err    = err_q;

    // The ALU only ever sees the latched operation, never the live request.
    assign alu_op1   = op1_q;
    assign alu_op2   = op2_q;
    assign alu_op    = aluop_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // Next-state and datapath capture for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        legal_d      = legal_q;
        zero_d       = zero_q;
        err_d        = err_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        result_d     = result_q;
        aluop_d      = aluop_q;
        case (state_q)
            IDLE: begin
                if (bus.req0_ready) begin
                    op1_d   = bus.req0_op1;
                    op2_d   = bus.req0_op2;
                    aluop_d = bus.req0_aluop;
                    legal_d = op_is_legal(bus.req0_aluop);
                    owner_d = 1'b0;
                    state_d = EXEC;
                end else if (bus.req1_ready) begin
                    op1_d   = bus.req1_op1;
                    op2_d   = bus.req1_op2;
                    aluop_d = bus.req1_aluop;
                    legal_d = op_is_legal(bus.req1_aluop);
                    owner_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (legal_q) begin
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    err_d    = 1'b0;
                end else begin
                    result_d = '0;
                    zero_d   = 1'b0;
                    err_d    = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            legal_q      <= 1'b0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            result_q     <= '0;
            aluop_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            legal_q      <= legal_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            result_q     <= result_d;
            aluop_q      <= aluop_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU, two request queues and a
// transaction-level model of the arbiter (who gets granted, when the response
// shows up, what it must contain).
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        busy;
    logic [1:0]  dbg_state;

    alu_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

    alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    function automatic bit legal_op(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13};
    endfunction

    // The shared ALU. Unimplemented codes give junk data and a set zero flag,
    // which the arbiter must hide behind err.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    return a ^ b;
            4'd9:    return ~(a | b);
            4'd10:   return a << b[4:0];
            4'd13:   return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_f(alu_op, alu_op1, alu_op2);
        alu_zero   = legal_op(alu_op) ? (alu_result == 32'd0) : 1'b1;
    end

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Expected responses in order, packed {err, zero, result}.
    logic [33:0] exp_q[$];
    op_t         q0[$];
    op_t         q1[$];
    int          grant_log[$];

    // transaction-level model state
    int  cyc        = 0;
    bit  out_v      = 0;
    int  out_owner  = 0;
    int  acc_cyc    = 0;
    op_t out_op;
    int  last_owner = 1;
    int  vprob      = 100;
    int  rprob      = 100;
    int  stall0     = 0;

    function automatic logic [33:0] expect_rsp(input op_t o);
        logic [31:0] r;
        if (!legal_op(o.op)) return {1'b1, 1'b0, 32'd0};
        r = alu_f(o.op, o.a, o.b);
        return {1'b0, (r == 32'd0), r};
    endfunction

    // driver: one clock cycle of stimulus plus all per-cycle checks
    task automatic step();
        int          exp_gnt;
        bit          vis, v0, v1, r0, r1, rsp_hs;
        logic [31:0] res_o;
        logic        zero_o, err_o;
        @(negedge clk);
        vis = out_v && (cyc >= acc_cyc + 2);
        v0  = (q0.size() > 0) && ($urandom_range(0, 99) < vprob);
        v1  = (q1.size() > 0) && ($urandom_range(0, 99) < vprob);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_op1   = v0 ? q0[0].a  : $urandom;
        bus.req0_op2   = v0 ? q0[0].b  : $urandom;
        bus.req0_aluop = v0 ? q0[0].op : 4'($urandom_range(0, 15));
        bus.req1_op1   = v1 ? q1[0].a  : $urandom;
        bus.req1_op2   = v1 ? q1[0].b  : $urandom;
        bus.req1_aluop = v1 ? q1[0].op : 4'($urandom_range(0, 15));
        r0 = (stall0 > 0) ? 1'b0 : ($urandom_range(0, 99) < rprob);
        r1 = ($urandom_range(0, 99) < rprob);
        bus.rsp0_ready = r0;
        bus.rsp1_ready = r1;
        if (vis && out_owner == 0 && stall0 > 0) stall0--;
        #1;
        exp_gnt = -1;
        if (!out_v) begin
            if (v0 && v1)  exp_gnt = 1 - last_owner;
            else if (v0)   exp_gnt = 0;
            else if (v1)   exp_gnt = 1;
        end
        check("req0_ready", 32'(bus.req0_ready), 32'(exp_gnt == 0));
        check("req1_ready", 32'(bus.req1_ready), 32'(exp_gnt == 1));
        check("busy", 32'(busy), 32'(out_v));
        check("rsp0_valid", 32'(bus.rsp0_valid), 32'(vis && out_owner == 0));
        check("rsp1_valid", 32'(bus.rsp1_valid), 32'(vis && out_owner == 1));
        if (out_v && cyc == acc_cyc + 1) begin
            check("alu_op1", alu_op1, out_op.a);
            check("alu_op2", alu_op2, out_op.b);
            check("alu_op", 32'(alu_op), 32'(out_op.op));
        end
        if (vis) begin
            res_o  = (out_owner == 1) ? bus.rsp1_result : bus.rsp0_result;
            zero_o = (out_owner == 1) ? bus.rsp1_zero   : bus.rsp0_zero;
            err_o  = (out_owner == 1) ? bus.rsp1_err    : bus.rsp0_err;
            check("rsp_result", res_o, exp_q[0][31:0]);
            check("rsp_zero", 32'(zero_o), 32'(exp_q[0][32]));
            check("rsp_err", 32'(err_o), 32'(exp_q[0][33]));
        end
        rsp_hs = vis && ((out_owner == 0) ? r0 : r1);
        @(posedge clk);
        if (rsp_hs) begin
            out_v      = 0;
            last_owner = out_owner;
            void'(exp_q.pop_front());
        end
        if (exp_gnt >= 0) begin
            out_op    = (exp_gnt == 0) ? q0.pop_front() : q1.pop_front();
            out_v     = 1;
            out_owner = exp_gnt;
            acc_cyc   = cyc;
            exp_q.push_back(expect_rsp(out_op));
            grant_log.push_back(exp_gnt);
        end
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || out_v) && n < 400) begin
            step();
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n >= 400), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'd0);
        check({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'd0);
        check({tag, "_rsp0_valid"}, 32'(bus.rsp0_valid), 32'd0);
        check({tag, "_rsp1_valid"}, 32'(bus.rsp1_valid), 32'd0);
        check({tag, "_rsp0_result"}, bus.rsp0_result, 32'd0);
        check({tag, "_rsp1_result"}, bus.rsp1_result, 32'd0);
        check({tag, "_rsp_zero"}, 32'({bus.rsp0_zero, bus.rsp1_zero}), 32'd0);
        check({tag, "_rsp_err"}, 32'({bus.rsp0_err, bus.rsp1_err}), 32'd0);
        check({tag, "_alu_op1"}, alu_op1, 32'd0);
        check({tag, "_alu_op2"}, alu_op2, 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    // Reset asserted mid-cycle, away from any clock edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_v      = 0;
        last_owner = 1;
        stall0     = 0;
        exp_q.delete();
    endtask

    function automatic op_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.op = op;
        o.a  = a;
        o.b  = b;
        return o;
    endfunction

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_aluop = '0;
        bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_aluop = '0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        // 1: ADD 5+7 on requester 0
        vprob = 100; rprob = 100;
        q0.push_back(mk(4'b0010, 32'd5, 32'd7));
        drain("t1");

        // 2: SUB 9-9 -> zero, then signed LESS -3 < 2
        q0.push_back(mk(4'b0110, 32'd9, 32'd9));
        drain("t2a");
        q1.push_back(mk(4'b0111, 32'hFFFF_FFFD, 32'd2));
        drain("t2b");

        // 3: continuous contention right after reset alternates 0,1,0,1
        pulse_reset("t3_rst");
        grant_log.delete();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mk(4'($urandom_range(0, 15)), $urandom, $urandom));
            q1.push_back(mk(4'($urandom_range(0, 15)), $urandom, $urandom));
        end
        drain("t3");
        check("t3_grant_count", 32'(grant_log.size()), 32'd12);
        for (int i = 0; i < grant_log.size(); i++)
            check("t3_grant_order", 32'(grant_log[i]), 32'(i % 2));

        // 4: requester 0 stalls its response for 4 cycles while requester 1 waits
        stall0 = 4;
        q0.push_back(mk(4'b0001, 32'h0F0F_0000, 32'h0000_00F0));
        q1.push_back(mk(4'b1000, 32'hAAAA_5555, 32'hFFFF_0000));
        drain("t4");

        // 5: unimplemented opcode, then a legal one
        q1.push_back(mk(4'b0011, 32'd100, 32'd200));
        drain("t5a");
        q1.push_back(mk(4'b0010, 32'd1, 32'd2));
        drain("t5b");

        // 6: reset during EXEC and during RESP drops the operation
        q0.push_back(mk(4'b0010, 32'd40, 32'd2));
        step();
        pulse_reset("t6_exec");
        repeat (3) step();
        stall0 = 50;
        q0.push_back(mk(4'b0110, 32'd40, 32'd2));
        step();
        step();
        pulse_reset("t6_resp");
        repeat (3) step();
        grant_log.delete();
        q0.push_back(mk(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0));
        q1.push_back(mk(4'b1001, 32'h1234_5678, 32'h0));
        drain("t6_after");
        check("t6_first_grant", 32'(grant_log[0]), 32'd0);

        // random traffic with dropped valids and random response back-pressure
        vprob = 70; rprob = 60;
        for (int i = 0; i < 60; i++) begin
            op_t o;
            o = mk(4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
            if ($urandom_range(0, 1) == 0) q0.push_back(o);
            else                           q1.push_back(o);
        end
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
